debug_uart_rx_core: RTL and testbench
=====================================

DEBUG_UART_RX_CORE -- requirements
Module: debug_uart_rx

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 191, clock cycles per UART bit (22 MHz / 191 = 115183 baud).
REQ-002 SHALL have parameter TICKS_PER_BIT_SIZE, default 8, bit-counter width; TICKS_PER_BIT < 2^TICKS_PER_BIT_SIZE.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_enable  input  1  high permits detection of a new start bit.
REQ-006 SHALL have port i_din_priortobuffer  input  1  raw asynchronous serial line, idle high.
REQ-007 SHALL have port o_rxdata  output  8  last accepted byte.
REQ-008 SHALL have port o_recvdata  output  1  one-cycle pulse when o_rxdata is updated.
REQ-009 SHALL have port o_busy  output  1  high while a frame is in progress.

Function
REQ-010 SHALL pass i_din_priortobuffer through a 2-flop synchronizer; all sampling uses the second flop (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH; frame format 8N1, LSB first.
REQ-012 IDLE: when i_enable=1 and rx_s=0, SHALL go to START, clear bit counter, assert o_busy.
REQ-013 START: counter increments each cycle; at counter = TICKS_PER_BIT/2 (integer division) SHALL sample rx_s: 0 -> DATA with counter cleared, 1 -> IDLE (false start, no pulse).
REQ-014 DATA: at counter = TICKS_PER_BIT-1 SHALL shift rx_s into the MSB of an 8-bit shift register (LSB-first assembly), clear counter; after the 8th bit go to STOP.
REQ-015 STOP: at counter = TICKS_PER_BIT-1 SHALL sample rx_s; valid stop (see REQ-024/025) -> o_rxdata <= shift register, o_recvdata=1, IDLE.
REQ-016 o_recvdata SHALL be high for exactly one cycle, on the same edge that o_busy falls.
REQ-017 o_busy SHALL be high in every state except IDLE.
REQ-018 o_rxdata SHALL change only when o_recvdata pulses; it holds between frames.
REQ-019 i_enable SHALL be ignored once a frame has started; the frame completes normally.
REQ-020 A new start bit SHALL be accepted in the cycle immediately following return to IDLE (back-to-back frames).
REQ-021 Counter arithmetic SHALL be TICKS_PER_BIT_SIZE bits wide, with no wrap within a bit period.

Reset
REQ-022 reset=0 at a clock edge SHALL force: state IDLE, counter 0, shift register 0, o_rxdata=8'h00, o_recvdata=0, o_busy=0, synchronizer flops=1.
REQ-023 Reset SHALL take priority mid-frame; the partial frame is discarded, no pulse.

Configuration
REQ-024 With macro DEBUG_UART_RX_FRAMING_CHECK_EN defined: stop sample 0 SHALL discard the byte (no pulse, o_rxdata unchanged) and enter WAIT_HIGH, which returns to IDLE on the first cycle rx_s=1; o_busy stays high in WAIT_HIGH.
REQ-025 Without DEBUG_UART_RX_FRAMING_CHECK_EN: stop sample SHALL be ignored, byte always delivered with pulse, WAIT_HIGH unused.

Verification (bench may use TICKS_PER_BIT=16, TICKS_PER_BIT_SIZE=5)
REQ-026 Frame 0x55, valid stop -> one o_recvdata pulse, o_rxdata=0x55, o_busy high from 3rd cycle after line fall to the pulse cycle.
REQ-027 Two back-to-back frames 0x0A then 0xA5 -> two pulses, o_rxdata 0x0A then 0xA5.
REQ-028 Line low for 3 cycles then high -> o_busy pulses for about TICKS_PER_BIT/2 cycles, returns IDLE, no o_recvdata, o_rxdata unchanged.
REQ-029 Frame 0x3C with stop=0 -> macro defined: no pulse, o_rxdata holds 0x55, o_busy stays high until line returns high; macro undefined: pulse, o_rxdata=0x3C.
REQ-030 reset=0 mid-data bit 4 -> next edge all outputs 0, state IDLE; following frame 0xC3 received correctly.
REQ-031 i_enable=0 during a full frame 0xFF -> o_busy stays 0, no pulse.

Source files
------------

// File: rtl/debug_uart_rx_core.sv
// Debug UART receiver: 8N1, LSB first, 2-flop synchronized input.
// Define DEBUG_UART_RX_FRAMING_CHECK_EN to drop bytes with a bad stop bit.
module debug_uart_rx_core #(
  parameter int TICKS_PER_BIT      = 191,
  parameter int TICKS_PER_BIT_SIZE = 8
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_din_priortobuffer,
  output logic [7:0] o_rxdata,
  output logic       o_recvdata,
  output logic       o_busy
);

  localparam int SZ = TICKS_PER_BIT_SIZE;
  localparam logic [SZ-1:0] C_HALF = SZ'(TICKS_PER_BIT / 2);
  localparam logic [SZ-1:0] C_LAST = SZ'(TICKS_PER_BIT - 1);
  localparam logic [SZ-1:0] C_ONE  = SZ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_sync1;
  logic          r_rx_s;
  logic [SZ-1:0] r_cnt;
  logic [SZ-1:0] w_cnt_nx;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nx;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nx;
  logic [7:0]    r_rxdata;
  logic [7:0]    w_rxdata_nx;
  logic          r_recv;
  logic          w_recv_nx;
  logic          r_busy;
  logic          w_busy_nx;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_bit_nx    = r_bit;
    w_shift_nx  = r_shift;
    w_rxdata_nx = r_rxdata;
    w_recv_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable && !r_rx_s) begin
          w_state_nx = S_START;
          w_cnt_nx   = '0;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nx   = '0;
          w_bit_nx   = 3'd0;
          w_state_nx = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nx = r_cnt + C_ONE;
        end
      end
      S_DATA: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nx   = '0;
          w_shift_nx = {r_rx_s, r_shift[7:1]};
          w_bit_nx   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nx = S_STOP;
          end
        end else begin
          w_cnt_nx = r_cnt + C_ONE;
        end
      end
      S_STOP: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nx = '0;
`ifdef DEBUG_UART_RX_FRAMING_CHECK_EN
          if (r_rx_s) begin
            w_rxdata_nx = r_shift;
            w_recv_nx   = 1'b1;
            w_state_nx  = S_IDLE;
          end else begin
            w_state_nx  = S_WAIT_HIGH;
          end
`else
          w_rxdata_nx = r_shift;
          w_recv_nx   = 1'b1;
          w_state_nx  = S_IDLE;
`endif
        end else begin
          w_cnt_nx = r_cnt + C_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // registered busy tracks the state, so it drops on the pulse edge
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      r_sync1  <= 1'b1;
      r_rx_s   <= 1'b1;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= 3'd0;
      r_shift  <= 8'h00;
      r_rxdata <= 8'h00;
      r_recv   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sync1  <= i_din_priortobuffer;
      r_rx_s   <= r_sync1;
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_bit    <= w_bit_nx;
      r_shift  <= w_shift_nx;
      r_rxdata <= w_rxdata_nx;
      r_recv   <= w_recv_nx;
      r_busy   <= w_busy_nx;
    end
  end

  assign o_rxdata   = r_rxdata;
  assign o_recvdata = r_recv;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_debug_uart_rx_core.sv
// Randomized bench for debug_uart_rx_core against a frame-level model.
// Model: each driven frame yields its byte unless the framing check drops it.
module tb_debug_uart_rx_core;
  localparam int TPB = 16;
  localparam int SZ  = 5;
`ifdef DEBUG_UART_RX_FRAMING_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       line = 1'b1;
  logic [7:0] rxd;
  logic       recv;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_last = 8'h00;
  logic [7:0] prev_rx = 8'h00;
  logic       prev_recv = 1'b0;

  always #5 clk = ~clk;

  debug_uart_rx_core #(
    .TICKS_PER_BIT(TPB),
    .TICKS_PER_BIT_SIZE(SZ)
  ) dut (
    .i_clk(clk),
    .reset(rst_n),
    .i_enable(en),
    .i_din_priortobuffer(line),
    .o_rxdata(rxd),
    .o_recvdata(recv),
    .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (recv === 1'b1) begin
      got_q.push_back(rxd);
      chk("busy_at_pulse", {31'd0, busy}, 32'd0);
      chk("pulse_width", {31'd0, prev_recv}, 32'd0);
    end else if (rst_n) begin
      chk("rx_hold", {24'd0, rxd}, {24'd0, prev_rx});
    end
    prev_rx   = rxd;
    prev_recv = recv;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input bit chk_rise, input bit exp_busy,
                           input bit drop_en);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line = fr[i];
      if (drop_en) en = (i >= 2 && i <= 8) ? 1'b0 : 1'b1;
      for (int c = 1; c <= TPB; c++) begin
        @(posedge clk);
        #1;
        if (chk_rise && i == 0 && c == 2)
          chk("busy_pre", {31'd0, busy}, 32'd0);
        if (chk_rise && i == 0 && c == 3)
          chk("busy_rise", {31'd0, busy}, 32'd1);
        if (i == 5 && c == TPB / 2)
          chk("busy_mid", {31'd0, busy}, {31'd0, exp_busy});
        if (!exp_busy)
          chk("busy_off", {31'd0, busy}, 32'd0);
      end
    end
  endtask

  task automatic model(input logic [7:0] b, input logic stop);
    if (stop || !FCHK) begin
      exp_q.push_back(b);
      exp_last = b;
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    if (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_last"}, {24'd0, got_q[$]}, {24'd0, exp_q[$]});
    chk({tag, "_out"}, {24'd0, rxd}, {24'd0, exp_last});
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         gap;
    bit         drop;

    tick(3);
    chk("rst_rx", {24'd0, rxd}, 32'd0);
    chk("rst_recv", {31'd0, recv}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick(4);

    send_byte(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    model(8'h55, 1'b1);
    check_rx("f55");
    tick(2 * TPB);

    line = 1'b0;
    tick(3);
    chk("fs_busy", {31'd0, busy}, 32'd1);
    line = 1'b1;
    tick(2 * TPB);
    chk("fs_idle", {31'd0, busy}, 32'd0);
    check_rx("fs");

    send_byte(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    model(8'h3C, 1'b0);
`ifdef DEBUG_UART_RX_FRAMING_CHECK_EN
    tick(TPB);
    chk("wait_high_busy", {31'd0, busy}, 32'd1);
`endif
    line = 1'b1;
    tick(2 * TPB);
    chk("bs_idle", {31'd0, busy}, 32'd0);
    check_rx("bs");

    send_byte(8'h0A, 1'b1, 1'b0, 1'b1, 1'b0);
    model(8'h0A, 1'b1);
    check_rx("b2b_0");
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    model(8'hA5, 1'b1);
    check_rx("b2b_1");
    tick(2 * TPB);

    b = 8'h96;
    line = 1'b0;
    tick(TPB);
    for (int k = 0; k < 4; k++) begin
      line = b[k];
      tick(TPB);
    end
    line = b[4];
    tick(TPB / 2);
    rst_n = 1'b0;
    tick(1);
    chk("mrst_rx", {24'd0, rxd}, 32'd0);
    chk("mrst_recv", {31'd0, recv}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    line = 1'b1;
    tick(2 * TPB);
    rst_n = 1'b1;
    tick(2);
    exp_q.delete();
    got_q.delete();
    exp_last = 8'h00;

    send_byte(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
    model(8'hC3, 1'b1);
    check_rx("post_rst");
    tick(TPB);

    en = 1'b0;
    send_byte(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_rx("en_off");
    en = 1'b1;
    tick(TPB);

    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : 2 + int'($urandom_range(0, 1));
      drop = bit'($urandom_range(0, 1));
      send_byte(b, stop, 1'b0, 1'b1, drop);
      model(b, stop);
      check_rx("rnd");
      line = 1'b1;
      tick(gap * TPB);
    end
    tick(2 * TPB);
    chk("end_idle", {31'd0, busy}, 32'd0);
    check_rx("end");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
